// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared declarations for the UART receiver slice:
//   uart_state_e    - receiver FSM state encoding (IDLE/START/DATA/STOP)
//   UART_DATA_BITS  - data bits per frame (8, LSB first on the wire)
//   UART_IDLE_LEVEL - level of an idle serial line (high)
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_rx_ram.sv
// -----------------------------------------------------------------------------
// uart_rx_ram
// Simple dual-port synchronous RAM: one write port, one read port, registered
// read data (one cycle latency). Read-during-write to the same address returns
// the old contents. No reset on the array so it maps onto block RAM.
// Ports:
//   clk        - clock
//   wr_en_i    - write enable
//   wr_addr_i  - write address (ADDR_LEN bits)
//   wr_data_i  - write data (DATA_LEN bits)
//   rd_addr_i  - read address (ADDR_LEN bits)
//   rd_data_o  - registered read data (DATA_LEN bits)
// -----------------------------------------------------------------------------
module uart_rx_ram #(
   parameter int ADDR_LEN = 9,
   parameter int DATA_LEN = 8
) (
   input  logic                clk,
   input  logic                wr_en_i,
   input  logic [ADDR_LEN-1:0] wr_addr_i,
   input  logic [DATA_LEN-1:0] wr_data_i,
   input  logic [ADDR_LEN-1:0] rd_addr_i,
   output logic [DATA_LEN-1:0] rd_data_o
);

   localparam int DEPTH = 1 << ADDR_LEN;

   logic [DATA_LEN-1:0] mem_q [0:DEPTH-1];
   logic [DATA_LEN-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with a show-ahead receive FIFO.
// The serial line is synchronised (2 flops, idle high), a falling edge starts a
// frame, the start bit is re-checked at its middle, 8 data bits are sampled one
// bit period apart (LSB first) and the stop bit one period after the last data
// bit. Completed bytes go into a FIFO of 2^FIFO_ASIZE-1 usable entries built on
// uart_rx_ram.
// Optional feature: define UART_RX_FRAME_CHECK_EN to drop bytes whose stop bit
// is low and pulse o_frame_err; otherwise the stop bit is ignored and
// o_frame_err is held at 0.
// Parameters:
//   UART_CLK_DIV - clk cycles per bit period (>= 8)
//   FIFO_ASIZE   - FIFO address width
// Ports:
//   clk         - clock
//   rst_n       - asynchronous active-low reset
//   i_uart_rx   - asynchronous serial input, idles high
//   rvalid      - rdata holds a received byte
//   rready      - consumer accepts rdata when rvalid is high
//   rdata       - received byte
//   o_overflow  - one-cycle pulse: byte dropped, FIFO full
//   o_frame_err - one-cycle pulse: stop bit sampled low (frame check builds)
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int UART_CLK_DIV = 434,
   parameter int FIFO_ASIZE   = 9
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_uart_rx,
   output logic                      rvalid,
   input  logic                      rready,
   output logic [UART_DATA_BITS-1:0] rdata,
   output logic                      o_overflow,
   output logic                      o_frame_err
);

   localparam int                  TIMER_W   = $clog2(UART_CLK_DIV);
   localparam logic [TIMER_W-1:0]  TIMER_ONE = TIMER_W'(1);
   localparam logic [TIMER_W-1:0]  BIT_LAST  = TIMER_W'(UART_CLK_DIV - 1);
   localparam logic [TIMER_W-1:0]  HALF_LAST = TIMER_W'(UART_CLK_DIV / 2 - 1);
   localparam int                  CNT_W     = $clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(UART_DATA_BITS - 1);
   localparam logic [FIFO_ASIZE-1:0] PTR_ONE = FIFO_ASIZE'(1);

   // ---------------------------------------------------------------- line sync
   logic rx_meta_q;
   logic rx_sync_q;
   logic rx_prev_q;
   logic rx_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= UART_IDLE_LEVEL;
         rx_sync_q <= UART_IDLE_LEVEL;
         rx_prev_q <= UART_IDLE_LEVEL;
      end else begin
         rx_meta_q <= i_uart_rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // Edge, not level: a line held low (break) cannot restart a frame.
   assign rx_fall = (rx_prev_q == UART_IDLE_LEVEL) && (rx_sync_q != UART_IDLE_LEVEL);

   // --------------------------------------------------------------- frame FSM
   uart_state_e               state_q;
   logic [TIMER_W-1:0]        timer_q;
   logic [CNT_W-1:0]          bit_cnt_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      stop_tick;
   logic                      stop_ok;
   logic                      wr_req;

   assign stop_tick = (state_q == ST_STOP) && (timer_q == BIT_LAST);

`ifdef UART_RX_FRAME_CHECK_EN
   assign stop_ok = (rx_sync_q == UART_IDLE_LEVEL);
`else
   assign stop_ok = 1'b1;
`endif

   assign wr_req = stop_tick && stop_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rx_fall) begin
                  state_q <= ST_START;
                  timer_q <= '0;
               end
            end
            ST_START: begin
               // Mid start bit: still low means a real frame, high was a glitch.
               if (timer_q == HALF_LAST) begin
                  timer_q   <= '0;
                  bit_cnt_q <= '0;
                  state_q   <= (rx_sync_q == UART_IDLE_LEVEL) ? ST_IDLE : ST_DATA;
               end else begin
                  timer_q <= timer_q + TIMER_ONE;
               end
            end
            ST_DATA: begin
               if (timer_q == BIT_LAST) begin
                  timer_q   <= '0;
                  shift_q   <= {rx_sync_q, shift_q[UART_DATA_BITS-1:1]};
                  bit_cnt_q <= bit_cnt_q + CNT_ONE;
                  if (bit_cnt_q == CNT_LAST) begin
                     state_q <= ST_STOP;
                  end
               end else begin
                  timer_q <= timer_q + TIMER_ONE;
               end
            end
            ST_STOP: begin
               if (timer_q == BIT_LAST) begin
                  timer_q <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  timer_q <= timer_q + TIMER_ONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               timer_q <= '0;
            end
         endcase
      end
   end

`ifdef UART_RX_FRAME_CHECK_EN
   logic frame_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= stop_tick && !stop_ok;
      end
   end

   assign o_frame_err = frame_err_q;
`else
   assign o_frame_err = 1'b0;
`endif

   // -------------------------------------------------------------------- FIFO
   // rd_ptr_q always addresses the entry on rdata; it only advances on a
   // consumer transfer, so the output slot is part of the 2^N-1 capacity.
   logic [FIFO_ASIZE-1:0]     wr_ptr_q, wr_ptr_d;
   logic [FIFO_ASIZE-1:0]     rd_ptr_q, rd_ptr_d;
   logic                      rvalid_q;
   logic                      overflow_q;
   logic                      full;
   logic                      rd_fire;
   logic                      wr_accept;
   logic                      wr_drop;
   logic [UART_DATA_BITS-1:0] ram_rd_data;

   assign full      = (wr_ptr_q + PTR_ONE) == rd_ptr_q;
   assign rd_fire   = rvalid_q && rready;
   // At full, a read in the same cycle frees the slot the write needs.
   assign wr_accept = wr_req && (!full || rd_fire);
   assign wr_drop   = wr_req && full && !rd_fire;
   assign wr_ptr_d  = wr_accept ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
   assign rd_ptr_d  = rd_fire ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rvalid_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         // Compared against the pre-write pointer: the RAM read issued this
         // edge only sees bytes written in earlier cycles.
         rvalid_q   <= (wr_ptr_q != rd_ptr_d);
         overflow_q <= wr_drop;
      end
   end

   uart_rx_ram #(
      .ADDR_LEN (FIFO_ASIZE),
      .DATA_LEN (UART_DATA_BITS)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (wr_accept),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (shift_q),
      .rd_addr_i (rd_ptr_d),
      .rd_data_o (ram_rd_data)
   );

   assign rvalid     = rvalid_q;
   // The RAM output register is not reset; mask it until a byte is valid.
   assign rdata      = rvalid_q ? ram_rd_data : '0;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int DIV      = 16;
   localparam int ASIZE    = 2;
   localparam int DEPTH    = (1 << ASIZE) - 1;
   localparam int HALF_CLK = 50;
   localparam int BIT_T    = DIV * 2 * HALF_CLK;
   localparam int SKEW_T   = BIT_T / 50;

`ifdef UART_RX_FRAME_CHECK_EN
   localparam bit FRAME_CHECK = 1'b1;
`else
   localparam bit FRAME_CHECK = 1'b0;
`endif

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       rx     = 1'b1;
   logic       rready = 1'b0;
   logic       rvalid;
   logic [7:0] rdata;
   logic       ovf;
   logic       ferr;

   uart_rx #(
      .UART_CLK_DIV (DIV),
      .FIFO_ASIZE   (ASIZE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_uart_rx   (rx),
      .rvalid      (rvalid),
      .rready      (rready),
      .rdata       (rdata),
      .o_overflow  (ovf),
      .o_frame_err (ferr)
   );

   always #HALF_CLK clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   int         ovf_exp  = 0;
   int         ovf_seen = 0;
   int         fe_exp   = 0;
   int         fe_seen  = 0;
   int         rv_cnt   = 0;
   bit         rand_ready = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Reference model of one frame's outcome, decided from the frame content and
   // the number of bytes still owed to the consumer (FIFO holds DEPTH bytes).
   task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int bit_t);
      string outcome;
      if (!stop_hi && FRAME_CHECK) begin
         fe_exp++;
         outcome = "frame_err";
      end else if (exp_q.size() >= DEPTH) begin
         ovf_exp++;
         outcome = "overflow";
      end else begin
         exp_q.push_back(b);
         outcome = "deliver";
      end
      $display("tx byte=0x%02h stop=%0d bit_t=%0d expect=%s", b, stop_hi, bit_t, outcome);
      rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_t);
      end
      rx = stop_hi;
      #(bit_t);
      rx = 1'b1;
   endtask

   task automatic set_ready(input bit v);
      @(posedge clk);
      #2;
      rready = v;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain_left"}, exp_q.size(), 0);
      repeat (5) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_rvalid"}, rvalid, 1'b0);
      check({name, "_rdata"}, rdata, 8'h00);
      check({name, "_overflow"}, ovf, 1'b0);
      check({name, "_frame_err"}, ferr, 1'b0);
   endtask

   // Random consumer back-pressure, applied just after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_ready) rready = ($urandom_range(0, 1) == 1);
      end
   end

   // Monitor: pops the scoreboard on every transfer and watches error pulses.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (ovf)  ovf_seen++;
         if (ferr) fe_seen++;
         if (prev_stall) begin
            check("stall_rvalid", rvalid, 1'b1);
            check("stall_rdata", rdata, prev_data);
         end
         if (rvalid && rready) begin
            rv_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rx_unexpected: actual=0x%02h required=no byte", rdata);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               $display("rx byte=0x%02h expected=0x%02h", rdata, e);
               if (rdata !== e) begin
                  failures++;
                  $display("FAIL rx_data: actual=0x%02h required=0x%02h", rdata, e);
               end
            end
         end
         prev_stall = rvalid && !rready;
         prev_data  = rdata;
      end
   end

   initial begin
      int rv0;
      logic [7:0] b;
      int bt;

      // Power-on reset
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      set_ready(1'b1);
      repeat (20) @(posedge clk);

      // Back-to-back frames
      send_frame(8'h55, 1'b1, BIT_T);
      send_frame(8'hA3, 1'b1, BIT_T);
      wait_drain("b2b");
      check("b2b_overflow", ovf_seen, ovf_exp);
      check("b2b_frame_err", fe_seen, fe_exp);

      // Short low glitch on an idle line, then a real frame
      rv0 = rv_cnt;
      rx = 1'b0;
      #(4 * 2 * HALF_CLK);
      rx = 1'b1;
      #(12 * BIT_T);
      check("glitch_no_rvalid", rv_cnt - rv0, 0);
      send_frame(8'h3C, 1'b1, BIT_T);
      wait_drain("after_glitch");

      // Fill past capacity with the consumer stalled
      set_ready(1'b0);
      for (int i = 1; i <= 4; i++) begin
         b = 8'(i);
         send_frame(b, 1'b1, BIT_T);
      end
      repeat (10) @(negedge clk);
      check("full_overflow", ovf_seen, ovf_exp);
      check("full_rvalid", rvalid, 1'b1);
      check("full_head", rdata, exp_q[0]);
      set_ready(1'b1);
      wait_drain("full");

      // Stop bit sampled low
      send_frame(8'h7E, 1'b0, BIT_T);
      #(BIT_T);
      wait_drain("stop_low");
      check("stop_low_frame_err", fe_seen, fe_exp);
      check("stop_low_overflow", ovf_seen, ovf_exp);

      // Reset in the middle of a frame, with a byte parked in the FIFO
      set_ready(1'b0);
      send_frame(8'h11, 1'b1, BIT_T);
      $display("tx byte=0xf0 interrupted by reset in data bit 4");
      rx = 1'b0;
      #(BIT_T);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b0;
         #(BIT_T);
      end
      rx = 1'b1;
      #(BIT_T / 2);
      rst_n = 1'b0;
      exp_q.delete();
      repeat (4) begin
         @(negedge clk);
         check_reset_outputs("midframe_rst");
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #(BIT_T / 2 + 4 * BIT_T);
      set_ready(1'b1);
      repeat (5) @(negedge clk);
      check("post_rst_rvalid", rvalid, 1'b0);
      send_frame(8'h0F, 1'b1, BIT_T);
      wait_drain("post_rst");

      // Random bytes at +/-2% baud with random back-pressure
      rand_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b  = 8'($urandom);
         bt = ($urandom_range(0, 1) == 1) ? BIT_T + SKEW_T : BIT_T - SKEW_T;
         send_frame(b, 1'b1, bt);
      end
      rand_ready = 1'b0;
      set_ready(1'b1);
      wait_drain("skew");

      check("final_overflow", ovf_seen, ovf_exp);
      check("final_frame_err", fe_seen, fe_exp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
